// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the two-requester memory bus arbiter.
package mem_bus_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;

  // Payload register is sized for the widest supported bus; narrower
  // instances zero-extend on capture and truncate on drive.
  localparam int unsigned REQ_ADDR_MAX = 32;
  localparam int unsigned REQ_DATA_MAX = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_e;

  typedef struct packed {
    logic                    we;
    logic [REQ_ADDR_MAX-1:0] addr;
    logic [REQ_DATA_MAX-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin picker; the requester not granted last wins a tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  // prio_q set means requester 1 is preferred on the next tie
  logic prio_q;
  logic prio_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = prio_q ? 2'b10 : 2'b01;
    end
  end

  // Pointer moves only when the grant is actually consumed
  always_comb begin
    prio_d = prio_q;
    if (advance && (grant != 2'b00)) begin
      prio_d = grant[0];
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates two valid/ready requesters onto a single registered-read memory port.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,

  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  state_e            state_q;
  state_e            state_d;
  mem_req_t          req_q;
  mem_req_t          req_d;
  logic              id_q;
  logic              id_d;
  logic [1:0]        rvalid_q;
  logic [1:0]        rvalid_d;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata0_d;
  logic [DATA_W-1:0] rdata1_q;
  logic [DATA_W-1:0] rdata1_d;

  logic [1:0]        arb_valid;
  logic [1:0]        grant;
  logic              hs;

  // Requests are only visible to the picker while idle and out of reset
  assign arb_valid = {req1_valid, req0_valid} & {2{(state_q == IDLE) && !rst}};
  assign hs        = |grant;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (arb_valid),
    .advance (hs),
    .grant   (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = req_q.we ? IDLE : WAIT;
      end
      WAIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory strobes are decoded from the state flop so reset drops them at once
  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    busy       = (state_q != IDLE);
    req0_ready = grant[0];
    req1_ready = grant[1];
    if (state_q == ACCESS) begin
      mem_en    = 1'b1;
      mem_we    = req_q.we;
      mem_addr  = ADDR_W'(req_q.addr);
      mem_wdata = DATA_W'(req_q.wdata);
    end
  end

  // Capture the winning request and route returning read data
  always_comb begin
    req_d    = req_q;
    id_d     = id_q;
    rvalid_d = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    if (hs) begin
      id_d = grant[1];
      if (grant[1]) begin
        req_d.we    = req1_we;
        req_d.addr  = REQ_ADDR_MAX'(req1_addr);
        req_d.wdata = REQ_DATA_MAX'(req1_wdata);
      end else begin
        req_d.we    = req0_we;
        req_d.addr  = REQ_ADDR_MAX'(req0_addr);
        req_d.wdata = REQ_DATA_MAX'(req0_wdata);
      end
    end

    if (state_q == WAIT) begin
      if (id_q) begin
        rvalid_d[1] = 1'b1;
        rdata1_d    = mem_rdata;
      end else begin
        rvalid_d[0] = 1'b1;
        rdata0_d    = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q    <= '0;
      id_q     <= 1'b0;
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      req_q    <= req_d;
      id_q     <= id_d;
      rvalid_q <= rvalid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign req0_rvalid = rvalid_q[0];
  assign req1_rvalid = rvalid_q[1];
  assign req0_rdata  = rdata0_q;
  assign req1_rdata  = rdata1_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a behavioral memory and an expectation scoreboard.
module tb_mem_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req0_we = 1'b0;
  logic [7:0] req0_addr = '0, req0_wdata = '0;
  logic       req1_valid = 1'b0, req1_we = 1'b0;
  logic [7:0] req1_addr = '0, req1_wdata = '0;
  logic       req0_ready, req0_rvalid, req1_ready, req1_rvalid;
  logic [7:0] req0_rdata, req1_rdata;
  logic       mem_en, mem_we, busy;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = '0;

  typedef struct { int id; logic [7:0] data; int cyc; } rd_exp_t;
  typedef struct { logic [7:0] addr; logic [7:0] data; int cyc; } wr_exp_t;

  rd_exp_t    rq[$];
  wr_exp_t    wq[$];
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  int         cyc = 0;
  int         strobe_cnt = 0;
  int         vec_cnt = 0;
  int         err_cnt = 0;

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_we     (req0_we),
    .req0_addr   (req0_addr),
    .req0_wdata  (req0_wdata),
    .req0_ready  (req0_ready),
    .req0_rvalid (req0_rvalid),
    .req0_rdata  (req0_rdata),
    .req1_valid  (req1_valid),
    .req1_we     (req1_we),
    .req1_addr   (req1_addr),
    .req1_wdata  (req1_wdata),
    .req1_ready  (req1_ready),
    .req1_rvalid (req1_rvalid),
    .req1_rdata  (req1_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory with one-cycle registered read
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: scoreboard pops, exclusivity and idle-bus checks
  always @(negedge clk) begin
    if (!rst) begin
      rd_exp_t re;
      wr_exp_t we_e;
      if (req0_ready || req1_ready)
        check("one_ready", 32'(req0_ready & req1_ready), 32'd0);
      if (!mem_en)
        check("idle_bus", 32'({mem_we, mem_addr, mem_wdata}), 32'd0);
      else
        strobe_cnt++;
      if (mem_en && mem_we) begin
        check("wr_pending", 32'(wq.size() > 0), 32'd1);
        if (wq.size() > 0) begin
          we_e = wq.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(we_e.addr));
          check("wr_data", 32'(mem_wdata), 32'(we_e.data));
          check("wr_lat", 32'(cyc - we_e.cyc), 32'd1);
        end
      end
      if (req0_rvalid || req1_rvalid) begin
        check("rv_pending", 32'(rq.size() > 0), 32'd1);
        check("rv_single", 32'(req0_rvalid & req1_rvalid), 32'd0);
        if (rq.size() > 0) begin
          re = rq.pop_front();
          check("rv_id", 32'(req1_rvalid), 32'(re.id));
          check("rv_data", 32'(req1_rvalid ? req1_rdata : req0_rdata), 32'(re.data));
          check("rv_lat", 32'(cyc - re.cyc), 32'd3);
        end
      end
    end
  end

  task automatic set_req(input bit id, input bit v, input bit we, input logic [7:0] a, input logic [7:0] d);
    if (id) begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    end else begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    end
  endtask

  task automatic push_exp(input bit id, input bit we, input logic [7:0] a, input logic [7:0] d);
    rd_exp_t r;
    wr_exp_t w;
    if (we) begin
      ref_mem[a] = d;
      w.addr = a; w.data = d; w.cyc = cyc;
      wq.push_back(w);
    end else begin
      r.id = int'(id); r.data = ref_mem[a]; r.cyc = cyc;
      rq.push_back(r);
    end
  endtask

  // Single handshake; returns the handshake cycle number (-1 on timeout)
  task automatic do_req(input bit id, input bit we, input logic [7:0] a, input logic [7:0] d, output int hs);
    hs = -1;
    set_req(id, 1'b1, we, a, d);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        hs = cyc;
        push_exp(id, we, a, d);
        break;
      end
    end
    check("handshake", 32'(hs >= 0), 32'd1);
    @(posedge clk); #1;
    set_req(id, 1'b0, we, a, d);
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 32'(rq.size() + wq.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int hs, prev, rel, g, s0;
    int order [4];
    int hst [4];

    // Reset values with both requesters asserting valid
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    check("rst_rvalid", 32'({req0_rvalid, req1_rvalid}), 32'd0);
    check("rst_rdata", 32'({req0_rdata, req1_rdata}), 32'd0);
    check("rst_mem", 32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    rel = cyc;

    // Preload addr i = i+3, back-to-back writes from requester 0
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, 1'b1, 8'(i), 8'(i + 3), hs);
      if (i == 0) check("first_hs", 32'(hs - rel), 32'd0);
      else        check("wr_rate", 32'(hs - prev), 32'd2);
      prev = hs;
    end
    drain();

    // Single read from requester 0
    do_req(1'b0, 1'b0, 8'd5, 8'd0, hs);
    check("acc_en", 32'({mem_en, mem_we, busy}), 32'b101);
    check("acc_addr", 32'(mem_addr), 32'd5);
    drain();
    check("rd5_data", 32'(req0_rdata), 32'd8);
    check("rd5_r1_rdata", 32'(req1_rdata), 32'd0);

    // Both requesters reading continuously must alternate
    g = 0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'd2;
    req1_we = 1'b0; req1_addr = 8'd6;
    for (int k = 0; k < 40 && g < 4; k++) begin
      @(negedge clk);
      if (req0_ready) begin
        push_exp(1'b0, 1'b0, 8'd2, 8'd0); order[g] = 0; hst[g] = cyc; g++;
      end else if (req1_ready) begin
        push_exp(1'b1, 1'b0, 8'd6, 8'd0); order[g] = 1; hst[g] = cyc; g++;
      end
      @(posedge clk); #1;
      if (g >= 1) req1_valid = 1'b1;
      if (g >= 4) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("rr_grants", 32'(g), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("rr_order", 32'(order[i]), 32'(i % 2));
      if (i > 0) check("rd_rate", 32'(hst[i] - hst[i-1]), 32'd3);
    end
    drain();
    check("rr_rdata0", 32'(req0_rdata), 32'd5);
    check("rr_rdata1", 32'(req1_rdata), 32'd9);

    // Write from requester 1 immediately followed by a read of the same address
    do_req(1'b1, 1'b1, 8'd3, 8'hAA, prev);
    do_req(1'b0, 1'b0, 8'd3, 8'd0, hs);
    check("wr_rd_gap", 32'(hs - prev), 32'd2);
    drain();
    check("raw_rdata", 32'(req0_rdata), 32'hAA);
    check("hold_rdata1", 32'(req1_rdata), 32'd9);

    // Reset during the WAIT cycle of a read
    do_req(1'b0, 1'b0, 8'd1, 8'd0, hs);
    @(posedge clk); #1;
    check("in_wait", 32'({busy, mem_en}), 32'b10);
    #2;
    rst = 1'b1;
    rq.delete();
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mem", 32'({mem_en, mem_we}), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_rvalid", 32'({req0_rvalid, req1_rvalid}), 32'd0);
    end
    check("abort_rdata", 32'({req0_rdata, req1_rdata}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rel = cyc;
    do_req(1'b1, 1'b0, 8'd0, 8'd0, hs);
    check("post_rst_hs", 32'(hs - rel), 32'd0);
    drain();
    check("post_rst_rdata", 32'(req1_rdata), 32'd3);

    // Requester 0 pulses valid while requester 1 owns the bus
    s0 = strobe_cnt;
    do_req(1'b1, 1'b0, 8'd4, 8'd0, hs);
    set_req(1'b0, 1'b1, 1'b1, 8'd7, 8'h55);
    @(negedge clk);
    check("blocked_ready", 32'(req0_ready), 32'd0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("blocked_strobes", 32'(strobe_cnt - s0), 32'd1);
    check("blocked_mem7", 32'(mem[7]), 32'(ref_mem[7]));
    check("blocked_rdata1", 32'(req1_rdata), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
